// File: rtl/mem_responder_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_responder_pkg : shared channel-state encoding and stats helpers
// Rev 1.0
// ---------------------------------------------------------------------------
package mem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    RESPOND = 2'd2,
    DRAIN   = 2'd3
  } chan_state_e;

  localparam int STAT_BITS = 16;

  function automatic logic [STAT_BITS-1:0] sat_inc(input logic [STAT_BITS-1:0] v);
    return (v == {STAT_BITS{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_responder_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rr_arbiter : round-robin arbiter, priority starts after the last grant
// Rev 1.0
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter  int NUM_REQ  = 4,
  localparam int IDX_BITS = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [NUM_REQ-1:0]  req,
  output logic [NUM_REQ-1:0]  grant,
  output logic [IDX_BITS-1:0] grant_idx,
  output logic                grant_valid
);

  logic [IDX_BITS-1:0] ptr;
  int                  cand;

  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    cand        = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = int'(ptr) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (enable && !grant_valid && req[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = IDX_BITS'(cand);
        grant[cand] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr <= '0;
    end else if (grant_valid) begin
      ptr <= (grant_idx == IDX_BITS'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_responder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_responder : multi-channel memory responder with round-robin grant
// Optional MEM_RESPONDER_STATS_EN adds saturating read/write grant counters.
// Rev 1.0
// ---------------------------------------------------------------------------
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int ADDR_BITS    = 8,
  parameter int DATA_BITS    = 16,
  parameter int NUM_CHANNELS = 4,
  parameter int LATENCY      = 2,
  parameter int WRITE_ENABLE = 1
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic [NUM_CHANNELS-1:0]                 mem_read_valid,
  input  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mem_read_address,
  output logic [NUM_CHANNELS-1:0]                 mem_read_ready,
  output logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  mem_read_data,
  input  logic [NUM_CHANNELS-1:0]                 mem_write_valid,
  input  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mem_write_address,
  input  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  mem_write_data,
  output logic [NUM_CHANNELS-1:0]                 mem_write_ready,
  input  logic                                    init_valid,
  input  logic [ADDR_BITS-1:0]                    init_address,
  input  logic [DATA_BITS-1:0]                    init_data
`ifdef MEM_RESPONDER_STATS_EN
  ,
  output logic [STAT_BITS-1:0]                    stat_reads,
  output logic [STAT_BITS-1:0]                    stat_writes
`endif
);

  localparam int DEPTH    = 2 ** ADDR_BITS;
  localparam int CNT_BITS = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int IDX_BITS = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

  logic [DATA_BITS-1:0] storage [DEPTH];
  chan_state_e          state    [NUM_CHANNELS];
  logic [CNT_BITS-1:0]  count    [NUM_CHANNELS];
  logic [DATA_BITS-1:0] captured [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] is_write;

  logic [NUM_CHANNELS-1:0] eligible;
  logic [NUM_CHANNELS-1:0] grant;
  logic [IDX_BITS-1:0]     grant_idx;
  logic                    grant_valid;
  logic                    arb_enable;
  logic                    grant_is_read;
  logic                    write_fire;

  generate
    for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_eligible
      assign eligible[i] = (state[i] == IDLE) && (mem_read_valid[i] || mem_write_valid[i]);
    end
  endgenerate

  // Preload owns the cycle: no grant, no pointer movement, and no grants while held in reset.
  assign arb_enable    = reset && !init_valid;
  assign grant_is_read = mem_read_valid[grant_idx];
  assign write_fire    = grant_valid && !grant_is_read && (WRITE_ENABLE != 0);

  rr_arbiter #(
    .NUM_REQ (NUM_CHANNELS)
  ) u_arbiter (
    .clk         (clk),
    .reset       (reset),
    .enable      (arb_enable),
    .req         (eligible),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  // Storage survives reset; init and a granted write never coincide.
  always_ff @(posedge clk) begin
    if (init_valid) begin
      storage[init_address] <= init_data;
    end else if (write_fire) begin
      storage[mem_write_address[grant_idx]] <= mem_write_data[grant_idx];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        state[i]    <= IDLE;
        count[i]    <= '0;
        captured[i] <= '0;
      end
      is_write        <= '0;
      mem_read_ready  <= '0;
      mem_write_ready <= '0;
      mem_read_data   <= '0;
    end else begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        case (state[i])
          IDLE: begin
            if (grant[i]) begin
              state[i]    <= WAIT;
              count[i]    <= CNT_BITS'(LATENCY - 1);
              is_write[i] <= !mem_read_valid[i];
              if (mem_read_valid[i]) captured[i] <= storage[mem_read_address[i]];
            end
          end
          WAIT: begin
            if (count[i] == '0) begin
              state[i] <= RESPOND;
              if (is_write[i]) begin
                mem_write_ready[i] <= 1'b1;
              end else begin
                mem_read_ready[i] <= 1'b1;
                mem_read_data[i]  <= captured[i];
              end
            end else begin
              count[i] <= count[i] - 1'b1;
            end
          end
          RESPOND: begin
            state[i]           <= DRAIN;
            mem_read_ready[i]  <= 1'b0;
            mem_write_ready[i] <= 1'b0;
          end
          DRAIN: begin
            if (!mem_read_valid[i] && !mem_write_valid[i]) state[i] <= IDLE;
          end
          default: state[i] <= IDLE;
        endcase
      end
    end
  end

`ifdef MEM_RESPONDER_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_reads  <= '0;
      stat_writes <= '0;
    end else if (grant_valid) begin
      if (grant_is_read) stat_reads  <= sat_inc(stat_reads);
      else               stat_writes <= sat_inc(stat_writes);
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// Bench for mem_responder: a write-enabled and a read-only instance share one
// stimulus stream and are checked against a transaction-timestamp model.
module tb_mem_responder;

  localparam int AB  = 8;
  localparam int DB  = 16;
  localparam int NC  = 4;
  localparam int LAT = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst_n;
  logic [NC-1:0]         rv, wv;
  logic [NC-1:0][AB-1:0] raddr, waddr;
  logic [NC-1:0][DB-1:0] wdata;
  logic                  init_valid;
  logic [AB-1:0]         init_addr;
  logic [DB-1:0]         init_data;
  logic [NC-1:0]         rr1, wr1, rr0, wr0;
  logic [NC-1:0][DB-1:0] rd1, rd0;
`ifdef MEM_RESPONDER_STATS_EN
  logic [15:0] sr1, sw1, sr0, sw0;
`endif

  mem_responder #(.ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CHANNELS(NC), .LATENCY(LAT), .WRITE_ENABLE(1)) dut_we1 (
    .clk(clk), .reset(rst_n),
    .mem_read_valid(rv), .mem_read_address(raddr), .mem_read_ready(rr1), .mem_read_data(rd1),
    .mem_write_valid(wv), .mem_write_address(waddr), .mem_write_data(wdata), .mem_write_ready(wr1),
    .init_valid(init_valid), .init_address(init_addr), .init_data(init_data)
`ifdef MEM_RESPONDER_STATS_EN
    , .stat_reads(sr1), .stat_writes(sw1)
`endif
  );

  mem_responder #(.ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CHANNELS(NC), .LATENCY(LAT), .WRITE_ENABLE(0)) dut_we0 (
    .clk(clk), .reset(rst_n),
    .mem_read_valid(rv), .mem_read_address(raddr), .mem_read_ready(rr0), .mem_read_data(rd0),
    .mem_write_valid(wv), .mem_write_address(waddr), .mem_write_data(wdata), .mem_write_ready(wr0),
    .init_valid(init_valid), .init_address(init_addr), .init_data(init_data)
`ifdef MEM_RESPONDER_STATS_EN
    , .stat_reads(sr0), .stat_writes(sw0)
`endif
  );

  // Reference model: per-channel transaction timestamps, two memory images.
  logic [DB-1:0]         mem1 [256];
  logic [DB-1:0]         mem0 [256];
  bit                    busy [NC];
  bit                    responded [NC];
  bit                    kind_rd [NC];
  int                    due [NC];
  int                    resp_edge [NC];
  logic [DB-1:0]         cap1 [NC];
  logic [DB-1:0]         cap0 [NC];
  logic [NC-1:0][DB-1:0] last1, last0;
  logic [NC-1:0]         exp_rr, exp_wr;
  int                    ptr, cyc, n_rd, n_wr;
  int                    checks, errors;
  bit                    auto_drop [NC];
  int                    cooldown [NC];

  function automatic int sat16(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit rel [NC];
    cyc++;
    exp_rr = '0;
    exp_wr = '0;
    if (!rst_n) begin
      for (int c = 0; c < NC; c++) begin
        busy[c] = 1'b0;
        responded[c] = 1'b0;
      end
      ptr = 0; n_rd = 0; n_wr = 0;
      last1 = '0; last0 = '0;
      if (init_valid) begin
        mem1[init_addr] = init_data;
        mem0[init_addr] = init_data;
      end
      return;
    end
    for (int c = 0; c < NC; c++) begin
      if (busy[c] && !responded[c] && due[c] == cyc) begin
        responded[c] = 1'b1;
        resp_edge[c] = cyc;
        if (kind_rd[c]) begin
          exp_rr[c] = 1'b1;
          last1[c]  = cap1[c];
          last0[c]  = cap0[c];
        end else begin
          exp_wr[c] = 1'b1;
        end
      end
    end
    for (int c = 0; c < NC; c++)
      rel[c] = busy[c] && responded[c] && (cyc >= resp_edge[c] + 2) && !rv[c] && !wv[c];
    if (init_valid) begin
      mem1[init_addr] = init_data;
      mem0[init_addr] = init_data;
    end else begin
      for (int k = 0; k < NC; k++) begin
        int c;
        c = (ptr + k) % NC;
        if (!busy[c] && (rv[c] || wv[c])) begin
          busy[c] = 1'b1;
          responded[c] = 1'b0;
          due[c] = cyc + LAT;
          kind_rd[c] = rv[c];
          if (rv[c]) begin
            cap1[c] = mem1[raddr[c]];
            cap0[c] = mem0[raddr[c]];
            n_rd++;
          end else begin
            mem1[waddr[c]] = wdata[c];
            n_wr++;
          end
          ptr = (c + 1) % NC;
          break;
        end
      end
    end
    for (int c = 0; c < NC; c++)
      if (rel[c]) begin
        busy[c] = 1'b0;
        responded[c] = 1'b0;
      end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("rd_ready_we1", rr1, exp_rr);
    chk("wr_ready_we1", wr1, exp_wr);
    chk("rd_ready_we0", rr0, exp_rr);
    chk("wr_ready_we0", wr0, exp_wr);
    chk("rd_data_we1", rd1, last1);
    chk("rd_data_we0", rd0, last0);
`ifdef MEM_RESPONDER_STATS_EN
    chk("stat_reads_we1", sr1, sat16(n_rd));
    chk("stat_writes_we1", sw1, sat16(n_wr));
    chk("stat_reads_we0", sr0, sat16(n_rd));
    chk("stat_writes_we0", sw0, sat16(n_wr));
`endif
    // Requester side: drop valid after ready and keep it low long enough to drain.
    for (int c = 0; c < NC; c++) begin
      if (cooldown[c] > 0) cooldown[c]--;
      if ((rr1[c] || wr1[c]) && auto_drop[c]) begin
        rv[c] = 1'b0;
        wv[c] = 1'b0;
        cooldown[c] = 2 + int'($urandom_range(0, 2));
      end
    end
  endtask

  task automatic wait_ready(input int ch, output int n);
    n = 0;
    while (1) begin
      step();
      n++;
      if (rr1[ch] || wr1[ch]) break;
      if (n >= 40) begin
        checks++;
        errors++;
        $error("FAIL ready_timeout ch%0d observed=no ready expected=ready within 40 cycles", ch);
        break;
      end
    end
  endtask

  initial begin
    int n, cnt;
    int first [NC];
    checks = 0; errors = 0; ptr = 0; cyc = 0; n_rd = 0; n_wr = 0;
    rst_n = 1'b0; rv = '0; wv = '0; raddr = '0; waddr = '0; wdata = '0;
    init_valid = 1'b0; init_addr = '0; init_data = '0;
    last1 = '0; last0 = '0;
    for (int c = 0; c < NC; c++) begin
      busy[c] = 1'b0; responded[c] = 1'b0; auto_drop[c] = 1'b1; cooldown[c] = 0;
    end

    // Preload every word while held in reset (also exercises reset-state outputs).
    for (int a = 0; a < 256; a++) begin
      init_valid = 1'b1;
      init_addr  = a[7:0];
      init_data  = DB'($urandom);
      step();
    end
    init_addr = 8'h10; init_data = 16'hBEEF;
    step();
    init_valid = 1'b0;
    rst_n = 1'b1;
    step();

    // Basic read latency and data.
    rv[0] = 1'b1; raddr[0] = 8'h10;
    wait_ready(0, n);
    chk("lat_read_ch0", n, 3);
    chk("data_read_ch0", rd1[0], 16'hBEEF);
    step();
    chk("read_ready_single_pulse", rr1[0], 1'b0);
    repeat (3) step();

    // Init in the same cycle as a pending read of that address.
    rv[3] = 1'b1; raddr[3] = 8'h30;
    init_valid = 1'b1; init_addr = 8'h30; init_data = 16'hCAFE;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    init_valid = 1'b0;
    wait_ready(3, n);
    chk("lat_init_blocked", n, 3);
    chk("data_init_blocked", rd1[3], 16'hCAFE);
    repeat (3) step();

    // Write then read back on another channel.
    wv[1] = 1'b1; waddr[1] = 8'h20; wdata[1] = 16'h1234;
    wait_ready(1, n);
    chk("lat_write_ch1", n, 3);
    step();
    chk("write_ready_single_pulse", wr1[1], 1'b0);
    repeat (3) step();
    rv[2] = 1'b1; raddr[2] = 8'h20;
    wait_ready(2, n);
    chk("data_readback_ch2", rd1[2], 16'h1234);
    repeat (3) step();

    // All four channels at once after a reset pulse.
    rst_n = 1'b0; step(); rst_n = 1'b1; step();
    for (int c = 0; c < NC; c++) begin
      rv[c] = 1'b1; raddr[c] = AB'(8'h10 + c); first[c] = -1;
    end
    for (int t = 1; t <= 20; t++) begin
      step();
      for (int c = 0; c < NC; c++) if (first[c] < 0 && rr1[c]) first[c] = t;
    end
    for (int c = 0; c < NC; c++) chk($sformatf("rr_order_ch%0d", c), first[c], 3 + c);

    // Valid held past ready: no second ready, regrant only after a low sample.
    auto_drop[0] = 1'b0;
    rv[0] = 1'b1; raddr[0] = 8'h44;
    wait_ready(0, n);
    cnt = 0;
    repeat (3) begin step(); if (rr1[0]) cnt++; end
    chk("no_second_ready", cnt, 0);
    rv[0] = 1'b0;
    step();
    rv[0] = 1'b1;
    wait_ready(0, n);
    chk("regrant_latency", n, 3);
    auto_drop[0] = 1'b1;
    repeat (4) step();

    // Reset during WAIT drops the transaction; storage survives.
    rv[0] = 1'b1; raddr[0] = 8'h10;
    step();
    rst_n = 1'b0; rv[0] = 1'b0;
    cnt = 0;
    repeat (2) begin step(); if (rr1[0]) cnt++; end
    rst_n = 1'b1;
    repeat (3) begin step(); if (rr1[0]) cnt++; end
    chk("no_ready_after_reset", cnt, 0);
    rv[0] = 1'b1; raddr[0] = 8'h10;
    wait_ready(0, n);
    chk("storage_kept_we1", rd1[0], 16'hBEEF);
    chk("storage_kept_we0", rd0[0], 16'hBEEF);
    repeat (3) step();

    // Read-only instance ignores the write yet completes the handshake.
    rst_n = 1'b0; step(); rst_n = 1'b1; step();
    wv[1] = 1'b1; waddr[1] = 8'h10; wdata[1] = 16'hFFFF;
    wait_ready(1, n);
    chk("ro_write_ready", wr0[1], 1'b1);
    repeat (3) step();
    rv[1] = 1'b1; raddr[1] = 8'h10;
    wait_ready(1, n);
    chk("ro_read_data", rd0[1], 16'hBEEF);
    chk("rw_read_data", rd1[1], 16'hFFFF);
`ifdef MEM_RESPONDER_STATS_EN
    chk("ro_stat_writes", sw0, 1);
    chk("ro_stat_reads", sr0, 1);
`endif
    repeat (3) step();

    // Randomized traffic with occasional preloads and one mid-run reset.
    for (int it = 0; it < 600; it++) begin
      init_valid = ($urandom_range(0, 7) == 0);
      init_addr  = AB'($urandom_range(0, 7));
      init_data  = DB'($urandom);
      if (it == 300) rst_n = 1'b0;
      if (it == 303) rst_n = 1'b1;
      for (int c = 0; c < NC; c++) begin
        if (!rv[c] && !wv[c] && cooldown[c] == 0 && $urandom_range(0, 2) == 0) begin
          case ($urandom_range(0, 2))
            0:       rv[c] = 1'b1;
            1:       wv[c] = 1'b1;
            default: begin rv[c] = 1'b1; wv[c] = 1'b1; end
          endcase
          raddr[c] = AB'($urandom_range(0, 7));
          waddr[c] = AB'($urandom_range(0, 7));
          wdata[c] = DB'($urandom);
        end
      end
      step();
    end
    init_valid = 1'b0;
    repeat (12) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
